// File: rtl/counter_sequence_monitor.sv
// counter_sequence_monitor
//   Watches a sampled counter stream and classifies each accepted sample
//   against the previous one as an increment, a decrement or an error.
//   It also tracks the run length of same-direction steps, locks onto a
//   direction after LOCK_THRESH consecutive steps, and keeps a saturating
//   error count.
//   Optional build macro: CSM_WRAP_EN. When it is defined, a step across the
//   2^WIDTH boundary is legal. When it is undefined, such a step is an error.
module counter_sequence_monitor #(
    parameter int WIDTH       = 4,
    parameter int STEP        = 1,
    parameter int LOCK_THRESH = 3,
    parameter int RUN_W       = 8,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             incr,
    output logic             decr,
    output logic             error,
    output logic             locked,
    output logic             lock_dir,
    output logic [RUN_W-1:0] run_len,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOCKED} state_t;

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
    localparam logic [31:0]      LOCK_T = 32'(LOCK_THRESH);

    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic             r_incr, r_decr, r_error;
    logic             r_locked, r_lock_dir;
    logic             r_dir;        // direction of the most recent legal step
    logic [RUN_W-1:0] r_run_len;
    logic [ERR_W-1:0] r_err_count;

    logic [WIDTH-1:0] w_up, w_dn;
    logic             w_up_ok, w_dn_ok;
    logic             w_is_up, w_is_dn, w_step, w_same, w_lock_hit;
    logic [RUN_W-1:0] w_run_step;

    function automatic logic [RUN_W-1:0] sat_run(input logic [RUN_W-1:0] v);
        return (&v) ? v : v + RUN_W'(1);
    endfunction

    function automatic logic [ERR_W-1:0] sat_err(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

`ifdef CSM_WRAP_EN
    assign w_up    = r_prev + STEP_V;
    assign w_up_ok = 1'b1;
    assign w_dn_ok = 1'b1;
`else
    // The extra carry bit flags an upward step that crosses the top of the range.
    logic [WIDTH:0] w_up_x;
    assign w_up_x  = {1'b0, r_prev} + (WIDTH+1)'(STEP);
    assign w_up    = w_up_x[WIDTH-1:0];
    assign w_up_ok = ~w_up_x[WIDTH];
    assign w_dn_ok = (r_prev >= STEP_V);
`endif

    assign w_dn       = r_prev - STEP_V;
    // If up and down land on the same value, the increment wins.
    assign w_is_up    = w_up_ok && (in_data == w_up);
    assign w_is_dn    = !w_is_up && w_dn_ok && (in_data == w_dn);
    assign w_step     = w_is_up | w_is_dn;
    // A zero run length means there is no previous step to continue.
    assign w_same     = (r_run_len != '0) && (r_dir == w_is_up);
    assign w_run_step = w_same ? sat_run(r_run_len) : RUN_W'(1);
    assign w_lock_hit = (32'(w_run_step) >= LOCK_T);

    // Direction-lock FSM with registered flags, run length and error count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_prev      <= '0;
            r_incr      <= 1'b0;
            r_decr      <= 1'b0;
            r_error     <= 1'b0;
            r_locked    <= 1'b0;
            r_lock_dir  <= 1'b0;
            r_dir       <= 1'b0;
            r_run_len   <= '0;
            r_err_count <= '0;
        end else if (clear) begin
            r_state     <= S_IDLE;
            r_prev      <= '0;
            r_incr      <= 1'b0;
            r_decr      <= 1'b0;
            r_error     <= 1'b0;
            r_locked    <= 1'b0;
            r_lock_dir  <= 1'b0;
            r_dir       <= 1'b0;
            r_run_len   <= '0;
            r_err_count <= '0;
        end else begin
            r_incr  <= 1'b0;
            r_decr  <= 1'b0;
            r_error <= 1'b0;
            if (in_valid) begin
                r_prev <= in_data;
                case (r_state)
                    S_IDLE: r_state <= S_TRACK;
                    S_TRACK: begin
                        if (w_step) begin
                            r_incr    <= w_is_up;
                            r_decr    <= w_is_dn;
                            r_dir     <= w_is_up;
                            r_run_len <= w_run_step;
                            if (w_lock_hit) begin
                                r_state    <= S_LOCKED;
                                r_locked   <= 1'b1;
                                r_lock_dir <= w_is_up;
                            end
                        end else begin
                            r_error     <= 1'b1;
                            r_run_len   <= '0;
                            r_err_count <= sat_err(r_err_count);
                        end
                    end
                    S_LOCKED: begin
                        if (w_step) begin
                            r_incr    <= w_is_up;
                            r_decr    <= w_is_dn;
                            r_dir     <= w_is_up;
                            r_run_len <= w_run_step;
                            if (w_is_up != r_lock_dir) begin
                                r_state    <= S_TRACK;
                                r_locked   <= 1'b0;
                                r_lock_dir <= 1'b0;
                            end
                        end else begin
                            r_error     <= 1'b1;
                            r_run_len   <= '0;
                            r_err_count <= sat_err(r_err_count);
                            r_state     <= S_TRACK;
                            r_locked    <= 1'b0;
                            r_lock_dir  <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign incr      = r_incr;
    assign decr      = r_decr;
    assign error     = r_error;
    assign locked    = r_locked;
    assign lock_dir  = r_lock_dir;
    assign run_len   = r_run_len;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_counter_sequence_monitor.sv
// Bench for counter_sequence_monitor. It uses two instances: STEP=1 (u_dut)
// and STEP=2 (u_dut2). Expected outputs are queued as each sample is driven
// and are popped and compared one cycle later. Define CSM_WRAP_EN here too
// when the design is built with it.
module tb_counter_sequence_monitor;

    typedef struct packed {
        logic       incr;
        logic       decr;
        logic       error;
        logic       locked;
        logic       lock_dir;
        logic [7:0] run_len;
        logic [7:0] err_count;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear, in_valid;
    logic [3:0] in_data;
    logic       incr, decr, error, locked, lock_dir;
    logic [7:0] run_len, err_count;

    logic       clear2, in_valid2;
    logic [3:0] in_data2;
    logic       incr2, decr2, error2, locked2, lock_dir2;
    logic [7:0] run_len2, err_count2;

    int   n_run  = 0;
    int   n_fail = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    counter_sequence_monitor #(.WIDTH(4), .STEP(1), .LOCK_THRESH(3), .RUN_W(8), .ERR_W(8)) u_dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .incr(incr), .decr(decr), .error(error), .locked(locked), .lock_dir(lock_dir),
        .run_len(run_len), .err_count(err_count)
    );

    counter_sequence_monitor #(.WIDTH(4), .STEP(2), .LOCK_THRESH(3), .RUN_W(8), .ERR_W(8)) u_dut2 (
        .clk(clk), .reset(reset), .clear(clear2), .in_valid(in_valid2), .in_data(in_data2),
        .incr(incr2), .decr(decr2), .error(error2), .locked(locked2), .lock_dir(lock_dir2),
        .run_len(run_len2), .err_count(err_count2)
    );

    function automatic obs_t mk(input logic i, input logic d, input logic e, input logic l,
                                input logic ld, input logic [7:0] r, input logic [7:0] c);
        obs_t o;
        o.incr = i; o.decr = d; o.error = e; o.locked = l; o.lock_dir = ld;
        o.run_len = r; o.err_count = c;
        return o;
    endfunction

    // lock_dir only carries meaning while locked
    function automatic obs_t obs1();
        return mk(incr, decr, error, locked, lock_dir & locked, run_len, err_count);
    endfunction

    function automatic obs_t obs2();
        return mk(incr2, decr2, error2, locked2, lock_dir2 & locked2, run_len2, err_count2);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("incr=%0b decr=%0b error=%0b locked=%0b dir=%0b run=%0d err=%0d",
                         o.incr, o.decr, o.error, o.locked, o.lock_dir, o.run_len, o.err_count);
    endfunction

    task automatic drive1(input logic v, input logic [3:0] d, input logic c);
        in_valid = v; in_data = d; clear = c;
        in_valid2 = 1'b0; in_data2 = 4'd0; clear2 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drive2(input logic v, input logic [3:0] d);
        in_valid = 1'b0; in_data = 4'd0; clear = 1'b0;
        in_valid2 = v; in_data2 = d; clear2 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0; #2; reset = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 4'd0;
        clear2 = 1'b0; in_valid2 = 1'b0; in_data2 = 4'd0;
        #12;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 8'd0, 8'd0));
        got = obs1(); want = exp_q.pop_front(); n_run++;
        if (got !== want || lock_dir !== 1'b0) begin
            n_fail++; $display("FAIL reset: got %s raw_dir=%0b, want %s", fmt(got), lock_dir, fmt(want));
        end
        #1 reset = 1'b1;
    endtask

    task automatic test_lock_up_and_down();
        logic [3:0] din [11] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd2};
        obs_t exp [11];
        obs_t got, want;
        exp = '{mk(0,0,0,0,0,8'd0,8'd0), mk(1,0,0,0,0,8'd1,8'd0), mk(1,0,0,0,0,8'd2,8'd0),
                mk(1,0,0,1,1,8'd3,8'd0), mk(0,1,0,0,0,8'd1,8'd0), mk(0,0,1,0,0,8'd0,8'd1),
                mk(0,1,0,0,0,8'd1,8'd1), mk(0,1,0,0,0,8'd2,8'd1), mk(0,1,0,1,0,8'd3,8'd1),
                mk(0,1,0,1,0,8'd4,8'd1), mk(1,0,0,0,0,8'd1,8'd1)};
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(exp[i]);
            drive1(1'b1, din[i], 1'b0);
            got = obs1(); want = exp_q.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++; $display("FAIL lock_seq[%0d] data=%0d: got %s, want %s", i, din[i], fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] din [4] = '{4'd14, 4'd15, 4'd0, 4'd15};
        obs_t exp [4];
        obs_t got, want;
`ifdef CSM_WRAP_EN
        exp = '{mk(0,0,0,0,0,8'd0,8'd0), mk(1,0,0,0,0,8'd1,8'd0),
                mk(1,0,0,0,0,8'd2,8'd0), mk(0,1,0,0,0,8'd1,8'd0)};
`else
        exp = '{mk(0,0,0,0,0,8'd0,8'd0), mk(1,0,0,0,0,8'd1,8'd0),
                mk(0,0,1,0,0,8'd0,8'd1), mk(0,0,1,0,0,8'd0,8'd2)};
`endif
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp[i]);
            drive1(1'b1, din[i], 1'b0);
            got = obs1(); want = exp_q.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++; $display("FAIL wrap[%0d] data=%0d: got %s, want %s", i, din[i], fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_step2_gaps();
        logic       vld [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] din [6] = '{4'd2, 4'd5, 4'd4, 4'd9, 4'd7, 4'd9};
        obs_t exp [6];
        obs_t got, want;
        exp = '{mk(0,0,0,0,0,8'd0,8'd0), mk(0,0,0,0,0,8'd0,8'd0), mk(1,0,0,0,0,8'd1,8'd0),
                mk(0,0,0,0,0,8'd1,8'd0), mk(0,0,1,0,0,8'd0,8'd1), mk(1,0,0,0,0,8'd1,8'd1)};
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exp[i]);
            drive2(vld[i], din[i]);
            got = obs2(); want = exp_q.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++; $display("FAIL step2[%0d] vld=%0b data=%0d: got %s, want %s", i, vld[i], din[i], fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_err_sat_clear();
        obs_t got, want;
        logic [7:0] e;
        pulse_reset();
        drive1(1'b1, 4'd5, 1'b0);
        for (int i = 1; i <= 260; i++) begin
            e = (i > 255) ? 8'd255 : 8'(i);
            exp_q.push_back(mk(0, 0, 1, 0, 0, 8'd0, e));
            drive1(1'b1, 4'd5, 1'b0);
            got = obs1(); want = exp_q.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++; $display("FAIL err_sat[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
        // clear beats in_valid, then the IDLE first sample, then a normal step
        exp_q.push_back(mk(0, 0, 0, 0, 0, 8'd0, 8'd0));
        drive1(1'b1, 4'd6, 1'b1);
        got = obs1(); want = exp_q.pop_front(); n_run++;
        if (got !== want) begin
            n_fail++; $display("FAIL clear_with_valid: got %s, want %s", fmt(got), fmt(want));
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 8'd0, 8'd0));
        drive1(1'b1, 4'd7, 1'b0);
        got = obs1(); want = exp_q.pop_front(); n_run++;
        if (got !== want) begin
            n_fail++; $display("FAIL after_clear_first: got %s, want %s", fmt(got), fmt(want));
        end
        exp_q.push_back(mk(1, 0, 0, 0, 0, 8'd1, 8'd0));
        drive1(1'b1, 4'd8, 1'b0);
        got = obs1(); want = exp_q.pop_front(); n_run++;
        if (got !== want) begin
            n_fail++; $display("FAIL after_clear_step: got %s, want %s", fmt(got), fmt(want));
        end
    endtask

    task automatic test_async_reset();
        obs_t got, want;
        exp_q.push_back(mk(1, 0, 0, 0, 0, 8'd2, 8'd0));
        drive1(1'b1, 4'd9, 1'b0);
        got = obs1(); want = exp_q.pop_front(); n_run++;
        if (got !== want) begin
            n_fail++; $display("FAIL pre_lock: got %s, want %s", fmt(got), fmt(want));
        end
        exp_q.push_back(mk(1, 0, 0, 1, 1, 8'd3, 8'd0));
        drive1(1'b1, 4'd10, 1'b0);
        got = obs1(); want = exp_q.pop_front(); n_run++;
        if (got !== want) begin
            n_fail++; $display("FAIL locked_before_reset: got %s, want %s", fmt(got), fmt(want));
        end
        in_valid = 1'b0;
        #3 reset = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 8'd0, 8'd0));
        got = obs1(); want = exp_q.pop_front(); n_run++;
        if (got !== want || lock_dir !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got %s raw_dir=%0b, want %s", fmt(got), lock_dir, fmt(want));
        end
        #2 reset = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 8'd0, 8'd0));
        drive1(1'b1, 4'd11, 1'b0);
        got = obs1(); want = exp_q.pop_front(); n_run++;
        if (got !== want) begin
            n_fail++; $display("FAIL post_reset_first: got %s, want %s", fmt(got), fmt(want));
        end
        exp_q.push_back(mk(1, 0, 0, 0, 0, 8'd1, 8'd0));
        drive1(1'b1, 4'd12, 1'b0);
        got = obs1(); want = exp_q.pop_front(); n_run++;
        if (got !== want) begin
            n_fail++; $display("FAIL post_reset_step: got %s, want %s", fmt(got), fmt(want));
        end
    endtask

    initial begin
        test_reset();
        test_lock_up_and_down();
        test_wrap();
        test_step2_gaps();
        test_err_sat_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
